// File: rtl/ace_pkg.sv
// rtl/ace_pkg.sv - shared types and encodings for the ACE read-return stage
package ace_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SNOOP,
        SNP_DATA,
        MEM_AR,
        MEM_R,
        WAIT_RACK,
        DONE
    } state_t;

    localparam int CRRESP_DATA_TRANSFER = 0;
    localparam int CRRESP_ERROR         = 1;
    localparam int CRRESP_PASS_DIRTY    = 2;
    localparam int CRRESP_IS_SHARED     = 3;
    localparam int CRRESP_WAS_UNIQUE    = 4;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;

endpackage

// File: rtl/ace_rack_watchdog.sv
// rtl/ace_rack_watchdog.sv - RACK wait counter with single-cycle expiry strobe
module ace_rack_watchdog #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn || !run || clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A RACK arriving in the final cycle wins over the timeout.
    assign expire = run && !clear && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/ace_read_return.sv
// rtl/ace_read_return.sv - ACE read-return stage (snoop data or memory fetch); optional RACK watchdog via ACE_RACK_TIMEOUT_EN
module ace_read_return
    import ace_pkg::*;
#(
    parameter int NUM_MASTERS             = 8,
    parameter int ID_SIZE                 = 8,
    parameter int ADDR_SIZE               = 32,
    parameter int DATA_SIZE               = 128,
    parameter int NUM_DATA_SIZE_CACHELINE = 4,
    parameter int RACK_TIMEOUT            = 256
) (
    input  logic                                           ACLK,
    input  logic                                           ARESETn,
    input  logic                                           req_vld,
    input  logic [$clog2(NUM_MASTERS)-1:0]                 req_master,
    input  logic [ID_SIZE-1:0]                             req_id,
    input  logic [ADDR_SIZE-1:0]                           req_addr,
    input  logic                                           data_rdy,
    input  logic                                           no_data,
    input  logic [NUM_DATA_SIZE_CACHELINE*DATA_SIZE-1:0]   cache_line_in,
    input  logic [4:0]                                     crresp_in,
    output logic                                           mem_arvalid,
    input  logic                                           mem_arready,
    output logic [ADDR_SIZE-1:0]                           mem_araddr,
    input  logic                                           mem_rvalid,
    input  logic [DATA_SIZE-1:0]                           mem_rdata,
    input  logic                                           mem_rlast,
    output logic                                           mem_rready,
    output logic [NUM_MASTERS*ID_SIZE-1:0]                 RID,
    output logic [NUM_MASTERS*DATA_SIZE-1:0]               RDATA,
    output logic [NUM_MASTERS*4-1:0]                       RRESP,
    output logic [NUM_MASTERS-1:0]                         RLAST,
    output logic [NUM_MASTERS-1:0]                         RVALID,
    input  logic [NUM_MASTERS-1:0]                         RREADY,
    input  logic [NUM_MASTERS-1:0]                         RACK,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           rack_timeout
);

    localparam int MW = $clog2(NUM_MASTERS);
    localparam int BW = $clog2(NUM_DATA_SIZE_CACHELINE);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_DATA_SIZE_CACHELINE - 1);

    state_t state, state_nxt;

    logic [MW-1:0]                                 sel_q;
    logic [ID_SIZE-1:0]                            id_q;
    logic [ADDR_SIZE-1:0]                          addr_q;
    logic [NUM_DATA_SIZE_CACHELINE*DATA_SIZE-1:0]  line_q;
    logic                                          is_shared_q;
    logic                                          pass_dirty_q;
    logic                                          error_q;
    logic [BW-1:0]                                 beat_q;

    logic                 lane_valid;
    logic                 lane_ready;
    logic                 lane_last;
    logic [DATA_SIZE-1:0] lane_data;
    logic [3:0]           lane_resp;
    logic                 rack_sel;
    logic                 wd_expire;
    logic                 unused_crresp;

    assign lane_ready    = RREADY[sel_q];
    assign rack_sel      = RACK[sel_q];
    assign busy          = (state != IDLE);
    assign mem_araddr    = (state == MEM_AR) ? addr_q : '0;
    assign unused_crresp = ^{crresp_in[CRRESP_DATA_TRANSFER], crresp_in[CRRESP_WAS_UNIQUE]};

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            sel_q        <= '0;
            id_q         <= '0;
            addr_q       <= '0;
            line_q       <= '0;
            is_shared_q  <= 1'b0;
            pass_dirty_q <= 1'b0;
            error_q      <= 1'b0;
            beat_q       <= '0;
        end else begin
            if (state == IDLE && req_vld) begin
                sel_q  <= req_master;
                id_q   <= req_id;
                addr_q <= req_addr;
            end
            if (state == WAIT_SNOOP && data_rdy) begin
                line_q       <= cache_line_in;
                is_shared_q  <= crresp_in[CRRESP_IS_SHARED];
                pass_dirty_q <= crresp_in[CRRESP_PASS_DIRTY];
                error_q      <= crresp_in[CRRESP_ERROR];
                beat_q       <= '0;
            end else if (state == SNP_DATA && lane_ready) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        lane_valid  = 1'b0;
        lane_data   = '0;
        lane_last   = 1'b0;
        lane_resp   = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (req_vld) state_nxt = WAIT_SNOOP;
            end
            WAIT_SNOOP: begin
                if (data_rdy) state_nxt = no_data ? MEM_AR : SNP_DATA;
            end
            SNP_DATA: begin
                lane_valid = 1'b1;
                lane_data  = line_q[DATA_SIZE*int'(beat_q) +: DATA_SIZE];
                lane_last  = (beat_q == LAST_BEAT);
                lane_resp  = {is_shared_q, pass_dirty_q, error_q ? RRESP_SLVERR : RRESP_OKAY};
                if (lane_ready && lane_last) state_nxt = WAIT_RACK;
            end
            MEM_AR: begin
                mem_arvalid = 1'b1;
                if (mem_arready) state_nxt = MEM_R;
            end
            MEM_R: begin
                // Memory beats pass straight through to the initiator; no buffering.
                lane_valid = mem_rvalid;
                lane_data  = mem_rdata;
                lane_last  = mem_rlast;
                lane_resp  = {is_shared_q, 1'b0, RRESP_OKAY};
                mem_rready = lane_ready;
                if (mem_rvalid && lane_ready && mem_rlast) state_nxt = WAIT_RACK;
            end
            WAIT_RACK: begin
                if (rack_sel || wd_expire) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        RID    = '0;
        RDATA  = '0;
        RRESP  = '0;
        RLAST  = '0;
        RVALID = '0;
        RVALID[sel_q]                               = lane_valid;
        RLAST[sel_q]                                = lane_last;
        RDATA[DATA_SIZE*int'(sel_q) +: DATA_SIZE]   = lane_data;
        RRESP[4*int'(sel_q) +: 4]                   = lane_resp;
        if (lane_valid) RID[ID_SIZE*int'(sel_q) +: ID_SIZE] = id_q;
    end

`ifdef ACE_RACK_TIMEOUT_EN
    ace_rack_watchdog #(
        .LIMIT (RACK_TIMEOUT)
    ) u_rack_watchdog (
        .clk    (ACLK),
        .resetn (ARESETn),
        .run    (state == WAIT_RACK),
        .clear  (rack_sel),
        .expire (wd_expire)
    );

    // Registered so the strobe lines up with the DONE cycle it causes.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rack_timeout <= 1'b0;
        end else begin
            rack_timeout <= wd_expire;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg   = (RACK_TIMEOUT > 0);
    assign wd_expire    = 1'b0;
    assign rack_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ace_read_return.sv
// tb/tb_ace_read_return.sv - randomized self-checking bench for ace_read_return
module tb_ace_read_return;

    localparam int NM  = 8;
    localparam int IDW = 8;
    localparam int AW  = 32;
    localparam int DW  = 128;
    localparam int NB  = 4;
    localparam int RT  = 16;

    logic                 ACLK = 1'b0;
    logic                 ARESETn = 1'b0;
    logic                 req_vld = 1'b0;
    logic [2:0]           req_master = '0;
    logic [IDW-1:0]       req_id = '0;
    logic [AW-1:0]        req_addr = '0;
    logic                 data_rdy = 1'b0;
    logic                 no_data = 1'b0;
    logic [NB*DW-1:0]     cache_line_in = '0;
    logic [4:0]           crresp_in = '0;
    logic                 mem_arvalid;
    logic                 mem_arready = 1'b0;
    logic [AW-1:0]        mem_araddr;
    logic                 mem_rvalid = 1'b0;
    logic [DW-1:0]        mem_rdata = '0;
    logic                 mem_rlast = 1'b0;
    logic                 mem_rready;
    logic [NM*IDW-1:0]    RID;
    logic [NM*DW-1:0]     RDATA;
    logic [NM*4-1:0]      RRESP;
    logic [NM-1:0]        RLAST;
    logic [NM-1:0]        RVALID;
    logic [NM-1:0]        RREADY = '0;
    logic [NM-1:0]        RACK = '0;
    logic                 busy;
    logic                 done;
    logic                 rack_timeout;

    always #5 ACLK = ~ACLK;

    ace_read_return #(
        .NUM_MASTERS             (NM),
        .ID_SIZE                 (IDW),
        .ADDR_SIZE               (AW),
        .DATA_SIZE               (DW),
        .NUM_DATA_SIZE_CACHELINE (NB),
        .RACK_TIMEOUT            (RT)
    ) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .req_vld       (req_vld),
        .req_master    (req_master),
        .req_id        (req_id),
        .req_addr      (req_addr),
        .data_rdy      (data_rdy),
        .no_data       (no_data),
        .cache_line_in (cache_line_in),
        .crresp_in     (crresp_in),
        .mem_arvalid   (mem_arvalid),
        .mem_arready   (mem_arready),
        .mem_araddr    (mem_araddr),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .mem_rlast     (mem_rlast),
        .mem_rready    (mem_rready),
        .RID           (RID),
        .RDATA         (RDATA),
        .RRESP         (RRESP),
        .RLAST         (RLAST),
        .RVALID        (RVALID),
        .RREADY        (RREADY),
        .RACK          (RACK),
        .busy          (busy),
        .done          (done),
        .rack_timeout  (rack_timeout)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [3:0]    resp;
    } beat_t;

    beat_t          exp_q[$];
    int             m_sel    = 0;
    logic [IDW-1:0] m_id     = '0;
    bit             m_active = 0;
    int             m_phase  = 0;
    int             done_cnt = 0;

    function automatic logic [3:0] exp_rresp(input logic [4:0] cr, input bit from_mem);
        if (from_mem) return {cr[3], 3'b000};
        return {cr[3], cr[2], (cr[1] ? 2'b10 : 2'b00)};
    endfunction

    bit             p_v = 0;
    bit             p_r = 0;
    logic           p_last;
    logic [DW-1:0]  p_data;
    logic           other_nz;
    logic           c_v, c_r;
    beat_t          c_b;

    always @(negedge ACLK) begin
        if (ARESETn) begin
            other_nz = 1'b0;
            for (int l = 0; l < NM; l++) begin
                if (!m_active || l != m_sel)
                    other_nz |= RVALID[l] | RLAST[l] | (|RDATA[l*DW +: DW]) |
                                (|RID[l*IDW +: IDW]) | (|RRESP[l*4 +: 4]);
            end
            check("unselected_lanes_zero", other_nz, 1'b0);
            if (m_phase == 2) begin
                check("mem_rready_follows", mem_rready, RREADY[m_sel]);
                check("mem_rvalid_passthru", RVALID[m_sel], mem_rvalid);
            end else begin
                check("mem_rready_quiet", mem_rready, 1'b0);
            end
            if (m_active) begin
                c_v = RVALID[m_sel];
                c_r = RREADY[m_sel];
                if (m_phase == 0) check("rvalid_outside_burst", c_v, 1'b0);
                if (c_v && c_r) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1'b1, 1'b0);
                    end else begin
                        c_b = exp_q.pop_front();
                        check("beat_data", RDATA[m_sel*DW +: DW], c_b.data);
                        check("beat_last", RLAST[m_sel], c_b.last);
                        check("beat_resp", RRESP[m_sel*4 +: 4], c_b.resp);
                        check("beat_id", RID[m_sel*IDW +: IDW], m_id);
                    end
                end
                if (p_v && !p_r) begin
                    check("stall_valid", c_v, 1'b1);
                    check("stall_data", RDATA[m_sel*DW +: DW], p_data);
                    check("stall_last", RLAST[m_sel], p_last);
                end
                p_v    = c_v;
                p_r    = c_r;
                p_data = RDATA[m_sel*DW +: DW];
                p_last = RLAST[m_sel];
            end else begin
                p_v = 0;
            end
            if (done) done_cnt++;
`ifndef ACE_RACK_TIMEOUT_EN
            check("rack_timeout_off", rack_timeout, 1'b0);
`endif
        end else begin
            p_v = 0;
        end
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive_ready(input int sel, input int mode, input int cyc);
        logic [NM-1:0] r;
        r = NM'($urandom);
        case (mode)
            0:       r[sel] = 1'b1;
            1:       r[sel] = cyc[0];
            default: r[sel] = ($urandom_range(0, 2) != 0);
        endcase
        RREADY = r;
    endtask

    task automatic run_txn(input int sel, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                           input bit nd, input logic [4:0] cr, input logic [NB*DW-1:0] line,
                           input int rmode, input bit early_rack, input bit stray,
                           input bit lit_en, input logic [3:0] lit_resp, input bit no_rack,
                           output int beat_cycles);
        logic [DW-1:0] mb[NB];
        int cyc, idx, d0, n;
        bit hs;
        req_vld = 1'b1; req_master = 3'(sel); req_id = id; req_addr = addr;
        m_sel = sel; m_id = id; m_active = 1;
        step();
        req_vld = 1'b0; req_master = 3'($urandom); req_id = IDW'($urandom); req_addr = $urandom;
        check("busy_after_req", busy, 1'b1);
        if (stray) begin
            req_vld = 1'b1; req_master = 3'((sel + 1) % NM); req_id = ~id;
            step();
            req_vld = 1'b0;
        end
        repeat ($urandom_range(0, 3)) step();
        data_rdy = 1'b1; no_data = nd; cache_line_in = line; crresp_in = cr;
        for (int b = 0; b < NB; b++) begin
            mb[b] = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back('{data: (nd ? mb[b] : line[b*DW +: DW]), last: (b == NB - 1),
                              resp: exp_rresp(cr, nd)});
        end
        if (!nd) m_phase = 1;
        step();
        data_rdy = 1'b0; no_data = 1'($urandom); crresp_in = 5'($urandom);
        cache_line_in = {16{$urandom}};
        cyc = 0;
        if (!nd) begin
            check("rvalid_after_data_rdy", RVALID[sel], 1'b1);
            if (lit_en) begin
                check("lit_rresp", RRESP[sel*4 +: 4], lit_resp);
                check("lit_rid", RID[sel*IDW +: IDW], id);
                check("lit_first_rlast", RLAST[sel], 1'b0);
            end
            while (exp_q.size() > 0 && cyc < 200) begin
                drive_ready(sel, rmode, cyc);
                if (early_rack) RACK[sel] = (exp_q.size() == 1);
                step();
                cyc++;
            end
        end else begin
            check("arvalid_after_data_rdy", mem_arvalid, 1'b1);
            check("araddr", mem_araddr, addr);
            repeat ($urandom_range(0, 3)) begin
                step();
                check("arvalid_held", mem_arvalid, 1'b1);
            end
            mem_arready = 1'b1;
            step();
            mem_arready = 1'b0;
            check("arvalid_drop", mem_arvalid, 1'b0);
            m_phase = 2;
            idx = 0;
            while (idx < NB && cyc < 200) begin
                if (!mem_rvalid) mem_rvalid = ($urandom_range(0, 3) != 0);
                mem_rdata = mem_rvalid ? mb[idx] : {$urandom, $urandom, $urandom, $urandom};
                mem_rlast = (idx == NB - 1);
                drive_ready(sel, rmode, cyc);
                if (early_rack) RACK[sel] = (idx == NB - 1);
                @(negedge ACLK);
                hs = mem_rvalid && RREADY[sel];
                step();
                if (hs) begin
                    idx++;
                    mem_rvalid = 1'b0;
                end
                cyc++;
            end
            mem_rvalid = 1'b0; mem_rlast = 1'b0;
        end
        m_phase = 0;
        RREADY = '0;
        RACK = '0;
        beat_cycles = cyc;
        check("burst_bounded", (cyc < 200), 1'b1);
        check("all_beats_seen", exp_q.size(), 0);
        exp_q.delete();
        d0 = done_cnt;
        if (no_rack) begin
`ifdef ACE_RACK_TIMEOUT_EN
            n = 0;
            while (!done && n < 100) begin
                step();
                n++;
            end
            check("wd_cycles", n, RT);
            check("wd_rack_timeout", rack_timeout, 1'b1);
            step();
            check("wd_timeout_pulse", rack_timeout, 1'b0);
            check("wd_idle", busy, 1'b0);
            check("wd_done_count", done_cnt - d0, 1);
            m_active = 0;
            return;
`else
            n = 0;
            repeat (40) begin
                step();
                if (busy) n++;
            end
            check("wait_rack_forever", n, 40);
            check("wait_rack_no_done", done_cnt - d0, 0);
`endif
        end
        if (stray && sel != 3) begin
            RACK[3] = 1'b1;
            step();
            RACK[3] = 1'b0;
        end
        step();
        check("no_done_before_rack", done_cnt - d0, 0);
        check("busy_wait_rack", busy, 1'b1);
        RACK[sel] = 1'b1;
        step();
        RACK[sel] = 1'b0;
        check("done_pulse", done, 1'b1);
        check("busy_in_done", busy, 1'b1);
        step();
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
        check("done_count", done_cnt - d0, 1);
        m_active = 0;
    endtask

    task automatic reset_mid_burst();
        int d0;
        req_vld = 1'b1; req_master = 3'd4; req_id = 8'hC3; req_addr = 32'h1000;
        m_sel = 4; m_id = 8'hC3; m_active = 1;
        step();
        req_vld = 1'b0;
        data_rdy = 1'b1; no_data = 1'b0; crresp_in = 5'b01000;
        cache_line_in = {16{$urandom}};
        for (int b = 0; b < NB; b++)
            exp_q.push_back('{data: cache_line_in[b*DW +: DW], last: (b == NB - 1),
                              resp: exp_rresp(5'b01000, 0)});
        m_phase = 1;
        RREADY = '1;
        step();
        data_rdy = 1'b0;
        step();
        step();
        d0 = done_cnt;
        ARESETn = 1'b0;
        step();
        check("rst_rvalid", RVALID, '0);
        check("rst_rdata", |RDATA, 1'b0);
        check("rst_rid", |RID, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_arvalid", mem_arvalid, 1'b0);
        exp_q.delete();
        m_active = 0; m_phase = 0;
        RREADY = '0;
        ARESETn = 1'b1;
        repeat (5) step();
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_still_idle", busy, 1'b0);
    endtask

    int bc;
    logic [NB*DW-1:0] ln;

    initial begin
        ARESETn = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_rvalid", RVALID, '0);
        check("reset_arvalid", mem_arvalid, 1'b0);
        check("reset_rready", mem_rready, 1'b0);
        check("reset_timeout", rack_timeout, 1'b0);
        ARESETn = 1'b1;
        step();

        ln = {16{$urandom}};
        run_txn(2, 8'h5A, 32'h0000_4000, 0, 5'b01101, ln, 0, 0, 0, 1, 4'b1100, 0, bc);
        check("hit_consecutive_beats", bc, 4);

        ln = {16{$urandom}};
        run_txn(2, 8'h33, 32'h0000_4040, 0, 5'b00000, ln, 1, 0, 0, 0, 4'b0000, 0, bc);

        run_txn(5, 8'h77, 32'hDEAD_BEC0, 1, 5'b00001, ln, 0, 0, 0, 0, 4'b0000, 0, bc);

        ln = {16{$urandom}};
        run_txn(2, 8'h11, 32'h0000_8000, 0, 5'b00010, ln, 2, 0, 1, 1, 4'b0010, 0, bc);

        run_txn(6, 8'h9E, 32'h0001_0000, 1, 5'b01000, ln, 2, 1, 1, 0, 4'b0000, 0, bc);
        ln = {16{$urandom}};
        run_txn(1, 8'h42, 32'h0002_0000, 0, 5'b00100, ln, 0, 1, 0, 0, 4'b0000, 0, bc);

        reset_mid_burst();

        ln = {16{$urandom}};
        run_txn(7, 8'hA5, 32'h0003_0000, 0, 5'b01001, ln, 0, 0, 0, 0, 4'b0000, 1, bc);

        for (int t = 0; t < 30; t++) begin
            ln = {16{$urandom}};
            run_txn($urandom_range(0, NM - 1), IDW'($urandom), $urandom, 1'($urandom),
                    5'($urandom), ln, $urandom_range(0, 2), 1'($urandom), 1'($urandom),
                    0, 4'b0000, 0, bc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ace_read_return.md
# ace_read_return

Read-return stage downstream of the cache-line aggregator in the ACE interconnect. It takes the aggregated snoop result for the winning read transaction: the full cache line, the merged CRRESP and the no-data flag. It returns the data to the initiating master on that master's R channel, either from snoop data or by fetching from memory. It then waits for RACK and releases the interconnect with a one-cycle `done`.

## Interface
- NUM_MASTERS, 8, number of ACE masters (R lanes)
- ID_SIZE, 8, transaction ID width
- ADDR_SIZE, 32, address width
- DATA_SIZE, 128, beat width
- NUM_DATA_SIZE_CACHELINE, 4, beats per cache line
- RACK_TIMEOUT, 256, RACK watchdog limit in cycles (used only with the macro)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous, active-low reset
- req_vld  in  1  read grant pulse from the arbiter path
- req_master  in  $clog2(NUM_MASTERS)  initiator index
- req_id  in  ID_SIZE  initiator ARID
- req_addr  in  ADDR_SIZE  line address
- data_rdy  in  1  aggregator result-valid pulse
- no_data  in  1  no snooped master supplied data; qualified by data_rdy
- cache_line_in  in  NUM_DATA_SIZE_CACHELINE*DATA_SIZE  aggregated line; beat i at [DATA_SIZE*i +: DATA_SIZE]
- crresp_in  in  5  merged CRRESP: bit0 DataTransfer, bit1 Error, bit2 PassDirty, bit3 IsShared, bit4 WasUnique
- mem_arvalid  out  1  memory read request
- mem_arready  in  1
- mem_araddr  out  ADDR_SIZE
- mem_rvalid  in  1
- mem_rdata  in  DATA_SIZE
- mem_rlast  in  1
- mem_rready  out  1
- RID  out  NUM_MASTERS*ID_SIZE
- RDATA  out  NUM_MASTERS*DATA_SIZE
- RRESP  out  NUM_MASTERS*4
- RLAST  out  NUM_MASTERS
- RVALID  out  NUM_MASTERS
- RREADY  in  NUM_MASTERS
- RACK  in  NUM_MASTERS
- busy  out  1  transaction in flight
- done  out  1  one-cycle completion pulse
- rack_timeout  out  1  one-cycle watchdog pulse; constant 0 without the macro

## Operation
- FSM states: IDLE, WAIT_SNOOP, SNP_DATA, MEM_AR, MEM_R, WAIT_RACK, DONE.
- IDLE:
  - req_vld captures master, id and addr, then goes to WAIT_SNOOP.
  - req_vld in any other state is ignored.
- WAIT_SNOOP: on data_rdy, capture cache_line_in and crresp_in.
  - If no_data=0, go to SNP_DATA.
  - If no_data=1, go to MEM_AR.
  - data_rdy in any other state is ignored.
- SNP_DATA:
  - Drive the selected lane with beat k, k = 0..N-1.
  - RLAST=1 on k=N-1.
  - k advances on RVALID&RREADY.
  - After the last handshake, go to WAIT_RACK.
  - RRESP = {IsShared, PassDirty, Error ? 2'b10 : 2'b00}.
- MEM_AR:
  - mem_arvalid=1 with mem_araddr = captured addr until mem_arready, then go to MEM_R.
- MEM_R: combinational pass-through on the selected lane.
  - RVALID = mem_rvalid; RDATA = mem_rdata; RLAST = mem_rlast.
  - mem_rready = RREADY[sel].
  - RRESP = {IsShared, 0, 00}.
  - The handshake with mem_rlast=1 goes to WAIT_RACK.
- WAIT_RACK: RACK[sel]=1 goes to DONE.
  - RACK on any other lane is ignored.
  - RACK before WAIT_RACK, including in the cycle of the last R handshake, is ignored.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Non-selected lanes are held at all-zero.
- On the selected lane, RID = captured id whenever RVALID=1.

## Timing
- Reset: all outputs 0 and FSM in IDLE at the first edge with ARESETn=0. Reset mid-transaction abandons the transaction with no done.
- req_vld at edge t: busy=1 from t+1.
- Snoop path:
  - data_rdy at edge t: RVALID[sel]=1 from t+1.
  - With RREADY tied high, N beats occupy t+1..t+N.
  - RVALID, RDATA and RLAST stay stable while RREADY=0.
- Memory path:
  - mem_arvalid is asserted in the cycle after data_rdy.
  - The R pass-through adds zero latency.
- RACK at edge t in WAIT_RACK: done=1 during cycle t+1; IDLE at t+2. A new req_vld is accepted from t+2.
- The beat counter is $clog2(NUM_DATA_SIZE_CACHELINE) bits wide and resets to 0 on entry to SNP_DATA.

## Configuration
- ACE_RACK_TIMEOUT_EN defined:
  - A counter runs in WAIT_RACK.
  - After RACK_TIMEOUT cycles without RACK, rack_timeout=1 for one cycle and the FSM goes to DONE, so done still pulses.
- ACE_RACK_TIMEOUT_EN undefined: rack_timeout is constant 0 and WAIT_RACK waits indefinitely.

## Structure
- ace_pkg:
  - state enum
  - CRRESP bit-index constants
  - RRESP OKAY/SLVERR encodings
- Sub-module ace_rack_watchdog: counter, clear and expiry pulse. Instantiated only under ACE_RACK_TIMEOUT_EN.

## Test plan
- Snoop hit: master 2, id 0x5A; data_rdy with no_data=0, crresp=5'b01101; RREADY=1.
  - Expect 4 beats on lane 2 in consecutive cycles, RLAST on the 4th, RRESP=4'b1100, RID=0x5A.
  - After RACK[2], expect one done pulse.
- Backpressure: toggle RREADY[2] every cycle.
  - Beats stay stable while stalled; order is 0,1,2,3; no beat is lost or duplicated.
- Miss to memory: no_data=1, IsShared=0.
  - mem_araddr = req_addr.
  - 4 memory beats forwarded with mem_rready = RREADY; RRESP=0.
  - WAIT_RACK reached after mem_rlast.
- Error and stray events:
  - crresp bit1=1 gives RRESP[1:0]=2'b10.
  - RACK on lane 3 while serving lane 2 is ignored.
  - A second req_vld while busy is ignored.
- Reset mid-burst: ARESETn=0 after beat 1.
  - All outputs 0 next cycle; busy=0; no done pulse.
- Watchdog (macro on, RACK_TIMEOUT=16): withhold RACK.
  - rack_timeout and done assert 16 cycles after entering WAIT_RACK.
  - With the macro off, busy stays high.
